// File: rtl/door_access_arbiter.sv
// door_access_arbiter
// Shares one card-validation engine among N_DOORS door controllers.
// A round-robin arbiter grants one door at a time. The captured card ID is
// then presented to the validator. Its verdict, or a timeout verdict, is
// returned to the granted door. Every door has its own wrong-card counter,
// which raises a sticky alarm and locks that door out of arbitration.
// Optional feature: define DOOR_ARB_DENY_COUNT_EN to add the deny_count
// output. It is a saturating count of all failed results.
module door_access_arbiter #(
  parameter int N_DOORS     = 4,
  parameter int ID_W        = 8,
  parameter int TIMEOUT     = 15,
  parameter int LOCKOUT_CNT = 3
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [N_DOORS-1:0]      req,
  input  logic [N_DOORS*ID_W-1:0] card_id,
  input  logic [N_DOORS-1:0]      alarm_clr,
  output logic [N_DOORS-1:0]      grant,
  output logic                    val_req,
  output logic [ID_W-1:0]         val_id,
  input  logic                    val_done,
  input  logic                    val_ok,
  output logic [N_DOORS-1:0]      result_valid,
  output logic                    result_ok,
  output logic                    timeout,
  output logic [N_DOORS-1:0]      alarm,
`ifdef DOOR_ARB_DENY_COUNT_EN
  output logic [15:0]             deny_count,
`endif
  output logic                    busy
);

  localparam int PTR_W = (N_DOORS > 1) ? $clog2(N_DOORS) : 1;
  localparam int CW    = PTR_W + 1;
  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);
  localparam logic [2:0] LOCK_MAX  = 3'(LOCKOUT_CNT);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_REPORT
  } state_t;

  state_t             state;
  state_t             state_next;

  logic [PTR_W-1:0]   ptr;
  logic [PTR_W-1:0]   cur_door;
  logic [7:0]         wait_cnt;
  logic               verdict;
  logic               to_flag;
  logic [2:0]         wrong_cnt [N_DOORS];

  logic [N_DOORS-1:0] eligible;
  logic               any_eligible;
  logic [PTR_W-1:0]   pick_idx;
  logic [CW-1:0]      cand;
  logic [ID_W-1:0]    pick_id;

  logic               do_grant;
  logic               wait_done_ok;
  logic               wait_timeout;
  logic               do_report;

  function automatic logic [N_DOORS-1:0] onehot(input logic [PTR_W-1:0] idx);
    logic [N_DOORS-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

  assign eligible = req & ~alarm;

  // Round-robin search: the first eligible door at or above the pointer, with wrap-around
  always_comb begin
    any_eligible = 1'b0;
    pick_idx     = '0;
    cand         = '0;
    for (int i = 0; i < N_DOORS; i++) begin
      cand = {1'b0, ptr} + CW'(i);
      if (cand >= CW'(N_DOORS)) begin
        cand = cand - CW'(N_DOORS);
      end
      if (!any_eligible && eligible[cand[PTR_W-1:0]]) begin
        any_eligible = 1'b1;
        pick_idx     = cand[PTR_W-1:0];
      end
    end
  end

  // Card ID of the door that would be granted this cycle
  always_comb begin
    pick_id = card_id[pick_idx*ID_W +: ID_W];
  end

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic and transaction strobes. val_done takes priority over the timeout.
  always_comb begin
    state_next   = state;
    do_grant     = 1'b0;
    wait_done_ok = 1'b0;
    wait_timeout = 1'b0;
    do_report    = 1'b0;
    case (state)
      S_IDLE: begin
        if (any_eligible) begin
          do_grant   = 1'b1;
          state_next = S_WAIT;
        end
      end
      S_WAIT: begin
        if (val_done) begin
          wait_done_ok = 1'b1;
          state_next   = S_REPORT;
        end else if (wait_cnt == WAIT_LAST) begin
          wait_timeout = 1'b1;
          state_next   = S_REPORT;
        end
      end
      S_REPORT: begin
        do_report  = 1'b1;
        state_next = S_IDLE;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  // Grant pulse, captured door and ID, and the validator request level
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      grant    <= '0;
      cur_door <= '0;
      val_id   <= '0;
      val_req  <= 1'b0;
    end else begin
      grant <= do_grant ? onehot(pick_idx) : '0;
      if (do_grant) begin
        cur_door <= pick_idx;
        val_id   <= pick_id;
        val_req  <= 1'b1;
      end else if (wait_done_ok || wait_timeout) begin
        val_req <= 1'b0;
      end
    end
  end

  // Wait counter, and the verdict held for the report cycle
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wait_cnt <= '0;
      verdict  <= 1'b0;
      to_flag  <= 1'b0;
    end else begin
      if (do_grant) begin
        wait_cnt <= '0;
      end else if (state == S_WAIT) begin
        wait_cnt <= wait_cnt + 8'd1;
      end
      if (wait_done_ok) begin
        verdict <= val_ok;
        to_flag <= 1'b0;
      end else if (wait_timeout) begin
        verdict <= 1'b0;
        to_flag <= 1'b1;
      end
    end
  end

  // Result pulse to the granted door; the pointer advances past that door
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      result_valid <= '0;
      result_ok    <= 1'b0;
      timeout      <= 1'b0;
      ptr          <= '0;
    end else begin
      result_valid <= do_report ? onehot(cur_door) : '0;
      result_ok    <= do_report & verdict;
      timeout      <= do_report & to_flag;
      if (do_report) begin
        ptr <= (cur_door == PTR_W'(N_DOORS - 1)) ? '0 : cur_door + 1'b1;
      end
    end
  end

  // Per-door wrong-card counters and sticky alarms. A clear pulse wins over a coinciding result.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      alarm <= '0;
      for (int d = 0; d < N_DOORS; d++) begin
        wrong_cnt[d] <= '0;
      end
    end else begin
      for (int d = 0; d < N_DOORS; d++) begin
        if (alarm_clr[d]) begin
          alarm[d]     <= 1'b0;
          wrong_cnt[d] <= (do_report && cur_door == PTR_W'(d) && !verdict) ? 3'd1 : 3'd0;
        end else if (do_report && cur_door == PTR_W'(d)) begin
          if (verdict) begin
            wrong_cnt[d] <= 3'd0;
          end else if (wrong_cnt[d] < LOCK_MAX) begin
            wrong_cnt[d] <= wrong_cnt[d] + 3'd1;
            if (wrong_cnt[d] + 3'd1 == LOCK_MAX) begin
              alarm[d] <= 1'b1;
            end
          end
        end
      end
    end
  end

  // Busy whenever the engine is not idle
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy <= 1'b0;
    end else begin
      busy <= (state_next != S_IDLE);
    end
  end

`ifdef DOOR_ARB_DENY_COUNT_EN
  // Saturating count of every failed result
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      deny_count <= '0;
    end else if (do_report && !verdict && deny_count != 16'hFFFF) begin
      deny_count <= deny_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_door_access_arbiter.sv
// tb_door_access_arbiter
// Transaction-level bench for door_access_arbiter. It plays both the doors
// and the validator. A reference model tracks the pointer, the wrong-card
// counts, the alarms and the deny count. It does this per transaction,
// using the arbitration and lockout rules.
module tb_door_access_arbiter;

  localparam int N   = 4;
  localparam int IDW = 8;
  localparam int TO  = 15;
  localparam int LK  = 3;

  logic             clk = 1'b0;
  logic             reset;
  logic [N-1:0]     req;
  logic [N*IDW-1:0] card_id;
  logic [N-1:0]     alarm_clr;
  logic [N-1:0]     grant;
  logic             val_req;
  logic [IDW-1:0]   val_id;
  logic             val_done;
  logic             val_ok;
  logic [N-1:0]     result_valid;
  logic             result_ok;
  logic             timeout;
  logic [N-1:0]     alarm;
  logic             busy;
`ifdef DOOR_ARB_DENY_COUNT_EN
  logic [15:0]      deny_count;
`endif

  int checks = 0;
  int errors = 0;

  int           m_ptr;
  int           m_cnt [N];
  logic [N-1:0] m_alarm;
  int           m_deny;

  door_access_arbiter #(
    .N_DOORS(N), .ID_W(IDW), .TIMEOUT(TO), .LOCKOUT_CNT(LK)
  ) dut (
    .clk(clk),
    .reset(reset),
    .req(req),
    .card_id(card_id),
    .alarm_clr(alarm_clr),
    .grant(grant),
    .val_req(val_req),
    .val_id(val_id),
    .val_done(val_done),
    .val_ok(val_ok),
    .result_valid(result_valid),
    .result_ok(result_ok),
    .timeout(timeout),
    .alarm(alarm),
`ifdef DOOR_ARB_DENY_COUNT_EN
    .deny_count(deny_count),
`endif
    .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got no_finish expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic modelReset();
    m_ptr   = 0;
    m_alarm = '0;
    m_deny  = 0;
    for (int d = 0; d < N; d++) m_cnt[d] = 0;
  endtask

  function automatic int modelPick(input logic [N-1:0] r);
    for (int i = 0; i < N; i++) begin
      int d;
      d = (m_ptr + i) % N;
      if (r[d] && !m_alarm[d]) return d;
    end
    return -1;
  endfunction

  task automatic modelReport(input int g, input bit fail, input logic [N-1:0] clr);
    for (int d = 0; d < N; d++) begin
      if (clr[d]) begin
        m_alarm[d] = 1'b0;
        m_cnt[d]   = (d == g && fail) ? 1 : 0;
      end else if (d == g) begin
        if (!fail) begin
          m_cnt[d] = 0;
        end else if (m_cnt[d] < LK) begin
          m_cnt[d] = m_cnt[d] + 1;
          if (m_cnt[d] == LK) m_alarm[d] = 1'b1;
        end
      end
    end
    if (fail && m_deny < 65535) m_deny = m_deny + 1;
    m_ptr = (g + 1) % N;
  endtask

  task automatic resetDut();
    reset     = 1'b1;
    req       = '0;
    alarm_clr = '0;
    val_done  = 1'b0;
    val_ok    = 1'b0;
    card_id   = '0;
    repeat (2) @(posedge clk);
    #1;
    modelReset();
    checkOutput("rst_grant", grant, 0);
    checkOutput("rst_val_req", val_req, 0);
    checkOutput("rst_val_id", val_id, 0);
    checkOutput("rst_result_valid", result_valid, 0);
    checkOutput("rst_result_ok", result_ok, 0);
    checkOutput("rst_timeout", timeout, 0);
    checkOutput("rst_alarm", alarm, 0);
    checkOutput("rst_busy", busy, 0);
`ifdef DOOR_ARB_DENY_COUNT_EN
    checkOutput("rst_deny_count", deny_count, 0);
`endif
    reset = 1'b0;
  endtask

  // One request/validate/report transaction. k is the WAIT cycle carrying val_done (k >= TO never answers).
  task automatic applyStimulus(input logic [N-1:0] req_pat, input int k, input bit ok,
                               input bit drop, input logic [N-1:0] clr_pat);
    int g;
    int n;
    int exp_n;
    bit timed_out;
    req = req_pat;
    for (int d = 0; d < N; d++) card_id[d*IDW +: IDW] = 8'($urandom);
    g = modelPick(req_pat);
    @(posedge clk);
    #1;
    checkOutput("result_pulse", result_valid, 0);
    if (g < 0) begin
      checkOutput("grant_none", grant, 0);
      checkOutput("busy_idle", busy, 0);
      req = '0;
      return;
    end
    checkOutput("grant", grant, 32'(1) << g);
    checkOutput("val_id", val_id, card_id[g*IDW +: IDW]);
    checkOutput("val_req_on", val_req, 1);
    checkOutput("busy_wait", busy, 1);
    if (drop) req[g] = 1'b0;
    n = 0;
    for (int i = 0; i < TO + 4; i++) begin
      val_done = (i == k);
      val_ok   = (i == k) ? ok : 1'($urandom);
      @(posedge clk);
      #1;
      n++;
      if (i == 0) checkOutput("grant_pulse", grant, 0);
      if (!val_req) break;
    end
    exp_n     = (k < TO) ? k + 1 : TO;
    timed_out = (k >= TO);
    checkOutput("val_req_len", n, exp_n);
    checkOutput("result_early", result_valid, 0);
    val_done  = 1'($urandom);
    val_ok    = 1'b1;
    alarm_clr = clr_pat;
    @(posedge clk);
    #1;
    val_done  = 1'b0;
    alarm_clr = '0;
    modelReport(g, timed_out || !ok, clr_pat);
    checkOutput("result_valid", result_valid, 32'(1) << g);
    checkOutput("result_ok", result_ok, (!timed_out && ok) ? 1 : 0);
    checkOutput("timeout", timeout, timed_out ? 1 : 0);
    checkOutput("busy_report", busy, 0);
    checkOutput("alarm", alarm, m_alarm);
    req = '0;
  endtask

  task automatic pulseClear(input logic [N-1:0] clr);
    alarm_clr = clr;
    @(posedge clk);
    #1;
    alarm_clr = '0;
    for (int d = 0; d < N; d++) begin
      if (clr[d]) begin
        m_alarm[d] = 1'b0;
        m_cnt[d]   = 0;
      end
    end
    checkOutput("alarm_clr", alarm, m_alarm);
  endtask

  initial begin
    resetDut();

    // Single request from door 1, validator answers in the third WAIT cycle
    req = 4'b0010;
    applyStimulus(4'b0010, 2, 1'b1, 1'b0, 4'b0000);
    checkOutput("ptr_after_single", m_ptr, 2);

    // Round-robin with every door requesting
    resetDut();
    for (int t = 0; t < 5; t++) begin
      applyStimulus(4'b1111, 0, 1'b1, 1'b0, 4'b0000);
    end

    // Timeout on door 2, then val_done colliding with the timeout cycle
    applyStimulus(4'b0100, TO + 2, 1'b1, 1'b0, 4'b0000);
    applyStimulus(4'b0100, TO - 1, 1'b1, 1'b0, 4'b0000);

    // Lockout of door 0; door 3 is still served; clearing re-enables door 0
    resetDut();
    for (int t = 0; t < LK; t++) applyStimulus(4'b0001, 1, 1'b0, 1'b0, 4'b0000);
    checkOutput("lock_alarm", alarm, 4'b0001);
    applyStimulus(4'b1001, 0, 1'b1, 1'b0, 4'b0000);
    applyStimulus(4'b0001, 0, 1'b1, 1'b0, 4'b0000);
    pulseClear(4'b0001);
    applyStimulus(4'b0001, 0, 1'b1, 1'b1, 4'b0000);

    // Clear coinciding with a fail leaves the count at one and the alarm clear
    for (int t = 0; t < LK - 1; t++) applyStimulus(4'b0010, 0, 1'b0, 1'b0, 4'b0000);
    applyStimulus(4'b0010, 0, 1'b0, 1'b0, 4'b0010);
    checkOutput("clr_fail_alarm", alarm[1], 0);
    for (int t = 0; t < LK - 1; t++) applyStimulus(4'b0010, 0, 1'b0, 1'b0, 4'b0000);
    checkOutput("clr_fail_relock", alarm[1], 1);

    // Randomized traffic
    for (int t = 0; t < 300; t++) begin
      int sel;
      int k;
      sel = $urandom_range(0, 9);
      if (sel < 5)      k = $urandom_range(0, 3);
      else if (sel < 7) k = $urandom_range(TO - 1, TO + 2);
      else              k = $urandom_range(0, TO + 2);
      applyStimulus(4'($urandom), k, ($urandom_range(0, 9) < 6),
                    ($urandom_range(0, 3) == 0),
                    ($urandom_range(0, 9) == 0) ? 4'($urandom) : 4'b0000);
      if (t % 15 == 14) pulseClear(4'($urandom));
    end

`ifdef DOOR_ARB_DENY_COUNT_EN
    checkOutput("deny_count", deny_count, m_deny);
`endif

    // Reset in the middle of WAIT
    resetDut();
    req = 4'b0100;
    @(posedge clk);
    #1;
    checkOutput("mid_grant", grant, 4'b0100);
    @(posedge clk);
    @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    checkOutput("mid_val_req", val_req, 0);
    checkOutput("mid_busy", busy, 0);
    checkOutput("mid_result", result_valid, 0);
    req = '0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    modelReset();
    for (int t = 0; t < 4; t++) begin
      val_done = 1'($urandom);
      @(posedge clk);
      #1;
      checkOutput("post_rst_result", result_valid, 0);
      checkOutput("post_rst_busy", busy, 0);
    end
    val_done = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/door_access_arbiter.md
Name: door_access_arbiter

Overview:
- Shares one card-validation engine between N_DOORS door controllers; each door raises a request with a card ID and receives a pass/fail result.
- Round-robin arbitration, one validation in flight, timeout on a stalled validator.
- Per-door wrong-card counting with sticky alarm and request lockout.
- Sits between the per-door controllers and the central validator.

Parameters:
- N_DOORS, 4, number of requesting doors (2..8)
- ID_W, 8, card ID width
- TIMEOUT, 15, max cycles in WAIT before the transaction fails (1..255)
- LOCKOUT_CNT, 3, consecutive failed results that raise alarm for a door (1..7)

Ports:
- clk  in  1  clock
- reset  in  1  reset
- req  in  N_DOORS  per-door request level, held until that door's result_valid
- card_id  in  N_DOORS*ID_W  per-door card ID; door d uses bits [d*ID_W +: ID_W]
- alarm_clr  in  N_DOORS  per-door alarm clear pulse
- grant  out  N_DOORS  one-hot, 1-cycle pulse when a door is selected
- val_req  out  1  request to validator, held high in WAIT
- val_id  out  ID_W  captured card ID, stable while val_req=1
- val_done  in  1  validator response strobe, sampled only in WAIT
- val_ok  in  1  validator verdict, qualified by val_done
- result_valid  out  N_DOORS  one-hot, 1-cycle result pulse to the granted door
- result_ok  out  1  verdict accompanying result_valid
- timeout  out  1  1-cycle pulse, coincident with result_valid, on a timed-out transaction
- alarm  out  N_DOORS  sticky per-door alarm
- busy  out  1  high in any state other than IDLE

Behaviour:
- Interface: reset is asynchronous, active-high; clock is clk. All outputs are registered.
- Reset values: state=IDLE; all outputs 0; round-robin pointer=0; wrong counters=0; alarm=0; wait counter=0.
- Eligibility: door d is eligible when req[d]=1 and alarm[d]=0. Requests from alarmed doors are ignored.
- IDLE: if any door is eligible, pick the first eligible door searching from the pointer upward (wrapping modulo N_DOORS).
  - At that edge: grant[g]=1 for 1 cycle, val_id<=card_id[g], val_req<=1, wait counter<=0, go to WAIT.
- WAIT: wait counter increments each cycle.
  - val_done=1: capture val_ok, val_req<=0, go to REPORT.
  - Otherwise, when the counter reaches TIMEOUT-1: val_req<=0, verdict=0, timeout flag set, go to REPORT.
  - If val_done and the timeout condition occur in the same cycle, val_done wins and timeout stays 0.
- REPORT (1 cycle): result_valid[g]=1, result_ok=verdict, timeout=flag. Pointer<=(g+1) mod N_DOORS. Go to IDLE.
- Latency: a request sampled in IDLE is granted at that edge. The minimum request-to-result path is 3 edges (grant, val_done in the first WAIT cycle, REPORT). The next grant can occur on the edge after REPORT.
- Wrong-card counter per door (3 bits, saturating at LOCKOUT_CNT), updated on the REPORT edge:
  - fail (including timeout): +1;
  - pass: cleared to 0.
- Alarm:
  - Set alarm[d] on the edge where the counter becomes LOCKOUT_CNT.
  - A pass result never clears alarm.
  - alarm_clr[d] clears alarm[d] and the counter. If alarm_clr[d] coincides with a fail for d, the counter ends at 1 and the alarm stays clear; with a pass, the counter ends at 0.
- A door dropping req after grant does not abort the transaction; its result is still reported. A door dropping req before grant is never granted.
- val_done outside WAIT is ignored.
- A door that becomes alarmed is never re-granted until cleared, even if req stays high.
- Reset mid-transaction returns to IDLE immediately; val_req drops asynchronously, and no result is issued.

Optional Feature:
- Macro DOOR_ARB_DENY_COUNT_EN.
- Defined: adds output deny_count [15:0]. It increments on every REPORT with verdict 0, saturates at 16'hFFFF, and is reset to 0.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
- Single request: req=4'b0010, card_id[1]=8'hA5, validator answers val_done=1, val_ok=1 two cycles after val_req -> grant=0010, val_id=A5, result_valid=0010, result_ok=1, timeout=0, pointer=2.
- Round-robin: req=4'b1111 held, validator always answers after 1 cycle -> grants in order 0001, 0010, 0100, 1000, 0001, each door releasing req after its result_valid.
- Timeout: req[2]=1, val_done never asserted -> val_req high exactly 15 cycles, then result_valid=0100, result_ok=0, timeout=1; door 2 counter=1.
- Lockout: door 0 gets 3 consecutive fails -> alarm=0001 on the third REPORT edge. Further req[0] is not granted while req[3] is granted normally. alarm_clr[0] pulse -> alarm=0 and door 0 is granted again.
- Collision: val_done=1, val_ok=1 on the same cycle the timeout would fire -> result_ok=1, timeout=0. Reset asserted mid-WAIT -> val_req=0, busy=0, no result_valid.
- With DOOR_ARB_DENY_COUNT_EN: 5 fail results and 2 pass results -> deny_count=5; after reset -> 0.
